xnor_popcount_acc: RTL and testbench

- Parametrised successor to the NAND-built 2-input XNOR: a per-lane WIDTH-bit XNOR plus a popcount, accumulated over a frame of input beats.
- Produces a match count per frame: the number of bit positions where a equals b, summed over the frame.
- Used as the similarity / compare datapath of later labs, for example binary-weight dot products and word-equality checks.
- Valid/ready handshake on both the input and the output side.

---
 rtl/xnor_pkg.sv | 15 +
 rtl/xnor_popcount.sv | 37 +++
 rtl/xnor_popcount_acc.sv | 115 +++++++++++
 tb/tb_xnor_popcount_acc.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_pkg.sv
// Shared types and width helpers for the XNOR popcount accumulator.
// Holds the frame FSM state enum and the clog2_p1 width function.
package xnor_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Bits needed to hold any value in 0..n.
    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational per-beat compare: bitwise XNOR of a and b plus its popcount.
// Ports: a, b (WIDTH) in; match (WIDTH) XNOR vector out; count (PC_W) out.
module xnor_popcount
    import xnor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PC_W  = clog2_p1(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] match,
    output logic [PC_W-1:0]  count
);

    // Leaves are padded to a power of two so the tree is balanced.
    localparam int N = 1 << $clog2(WIDTH);

    logic [N-1:0]    padded;
    logic [PC_W-1:0] sum [N];

    assign match  = ~(a ^ b);
    assign padded = N'(match);

    // Pairwise reduction: level s adds nodes i and i+s into node i.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sum[i] = PC_W'(padded[i]);
        end
        for (int s = 1; s < N; s = s * 2) begin
            for (int i = 0; i < N; i = i + 2 * s) begin
                sum[i] = sum[i] + sum[i+s];
            end
        end
        count = sum[0];
    end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Frame accumulator of XNOR match counts with valid/ready on both sides.
// Ports: clk, rst; in_valid/in_ready, a, b, in_last; out_valid/out_ready,
// out_count, out_beats, out_match_all.
module xnor_popcount_acc
    import xnor_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int PC_W      = clog2_p1(WIDTH),
    parameter int ACC_W     = clog2_p1(WIDTH * FRAME_LEN),
    parameter int BC_W      = clog2_p1(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic [BC_W-1:0]  out_beats,
    output logic             out_match_all
);

    state_t state_q;
    state_t state_d;

    logic [ACC_W-1:0] acc_q;
    logic [BC_W-1:0]  beats_q;
    logic             all_q;

    logic [WIDTH-1:0] match;
    logic [PC_W-1:0]  pc;

    logic [ACC_W-1:0] acc_sum;
    logic [BC_W-1:0]  beats_inc;
    logic             accept;
    logic             last_beat;
    logic             beat_all;

    xnor_popcount #(
        .WIDTH (WIDTH),
        .PC_W  (PC_W)
    ) u_pc (
        .a     (a),
        .b     (b),
        .match (match),
        .count (pc)
    );

    // Decoded from state, not in_ready, to keep the comb path acyclic.
    assign accept    = in_valid && (state_q == ACCUM);
    assign acc_sum   = acc_q + ACC_W'(pc);
    assign beats_inc = beats_q + BC_W'(1);
    assign last_beat = in_last || (beats_q == BC_W'(FRAME_LEN - 1));

    // A frame sums to WIDTH*beats only if every beat was a full match,
    // so a running AND of per-beat full matches gives the same flag.
    assign beat_all = all_q && (&match);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = !rst;
                if (accept && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            beats_q       <= '0;
            all_q         <= 1'b1;
            out_count     <= '0;
            out_beats     <= '0;
            out_match_all <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                out_count     <= acc_sum;
                out_beats     <= beats_inc;
                out_match_all <= beat_all;
                acc_q         <= '0;
                beats_q       <= '0;
                all_q         <= 1'b1;
            end else begin
                acc_q   <= acc_sum;
                beats_q <= beats_inc;
                all_q   <= beat_all;
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Bench for xnor_popcount_acc: directed frames plus randomized traffic
// checked against a frame-level match-count model.
module tb_xnor_popcount_acc;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_count;
    logic [2:0] out_beats;
    logic       out_match_all;

    int checks   = 0;
    int failures = 0;

    // Model state: frame in progress and the pending result.
    int f_cnt   = 0;
    int f_beats = 0;
    bit m_done  = 0;
    int m_cnt   = 0;
    int m_beats = 0;
    bit m_all   = 0;

    xnor_popcount_acc #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_count     (out_count),
        .out_beats     (out_beats),
        .out_match_all (out_match_all)
    );

    always #5 clk = ~clk;

    function automatic int nmatch(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i] == y[i]) n++;
        end
        return n;
    endfunction

    task automatic model_clear();
        f_cnt   = 0;
        f_beats = 0;
        m_done  = 0;
    endtask

    // Drive one cycle of inputs, step past the edge, update the model.
    task automatic cycle(input logic v, input logic [7:0] x,
                         input logic [7:0] y, input logic l,
                         input logic r);
        in_valid  = v;
        a         = x;
        b         = y;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
        if (m_done) begin
            if (r) m_done = 0;
        end else if (v) begin
            f_cnt   += nmatch(x, y);
            f_beats += 1;
            if (l || f_beats == FRAME_LEN) begin
                m_done  = 1;
                m_cnt   = f_cnt;
                m_beats = f_beats;
                m_all   = (f_cnt == WIDTH * f_beats);
                f_cnt   = 0;
                f_beats = 0;
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%0b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
        end
        if (out_count !== 6'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", out_count);
        end
        if (out_beats !== 3'd0) begin
            failures++; $display("FAIL reset_beats got=%0d exp=0", out_beats);
        end
        if (out_match_all !== 1'b0) begin
            failures++; $display("FAIL reset_all got=%0b exp=0", out_match_all);
        end
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%0b exp=0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_ready got=%0b exp=1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_full_match();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL p1_early_valid beat=%0d got=1 exp=0", i);
            end
            cycle(1, 8'hFF, 8'hFF, 0, 1);
        end
        checks += 5;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL p1_valid got=%0b exp=1", out_valid);
        end
        if (out_count !== 6'd32) begin
            failures++; $display("FAIL p1_count got=%0d exp=32", out_count);
        end
        if (out_beats !== 3'd4) begin
            failures++; $display("FAIL p1_beats got=%0d exp=4", out_beats);
        end
        if (out_match_all !== 1'b1) begin
            failures++; $display("FAIL p1_all got=%0b exp=1", out_match_all);
        end
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL p1_ready_done got=%0b exp=0", in_ready);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
        checks += 2;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL p1_ready_back got=%0b exp=1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL p1_valid_drop got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_no_match();
        for (int i = 0; i < 4; i++) cycle(1, 8'h0F, 8'hF0, 0, 1);
        checks += 4;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL p2_valid got=%0b exp=1", out_valid);
        end
        if (out_count !== 6'd0) begin
            failures++; $display("FAIL p2_count got=%0d exp=0", out_count);
        end
        if (out_beats !== 3'd4) begin
            failures++; $display("FAIL p2_beats got=%0d exp=4", out_beats);
        end
        if (out_match_all !== 1'b0) begin
            failures++; $display("FAIL p2_all got=%0b exp=0", out_match_all);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_early_last();
        cycle(1, 8'hA5, 8'hA4, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL p3_early_valid got=%0b exp=0", out_valid);
        end
        cycle(1, 8'h00, 8'h00, 1, 1);
        checks += 4;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL p3_valid got=%0b exp=1", out_valid);
        end
        if (out_count !== 6'd15) begin
            failures++; $display("FAIL p3_count got=%0d exp=15", out_count);
        end
        if (out_beats !== 3'd2) begin
            failures++; $display("FAIL p3_beats got=%0d exp=2", out_beats);
        end
        if (out_match_all !== 1'b0) begin
            failures++; $display("FAIL p3_all got=%0b exp=0", out_match_all);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
        // in_last on the very first beat
        cycle(1, 8'h3C, 8'h3D, 1, 0);
        checks += 2;
        if (out_beats !== 3'd1) begin
            failures++; $display("FAIL first_last_beats got=%0d exp=1", out_beats);
        end
        if (out_count !== 6'd7) begin
            failures++; $display("FAIL first_last_count got=%0d exp=7", out_count);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) cycle(1, 8'h5A, 8'h5A, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 0);
            checks += 3;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL p4_hold_valid cyc=%0d got=%0b exp=1", i, out_valid);
            end
            if (out_count !== 6'd32) begin
                failures++; $display("FAIL p4_hold_count cyc=%0d got=%0d exp=32", i, out_count);
            end
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL p4_hold_ready cyc=%0d got=%0b exp=0", i, in_ready);
            end
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL p4_release got=%0b exp=0", out_valid);
        end
        for (int i = 0; i < 4; i++) cycle(1, 8'h00, 8'hFF, 0, 1);
        checks += 2;
        if (out_count !== 6'd0) begin
            failures++; $display("FAIL p4_residue_count got=%0d exp=0", out_count);
        end
        if (out_beats !== 3'd4) begin
            failures++; $display("FAIL p4_residue_beats got=%0d exp=4", out_beats);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_reset_mid_frame();
        cycle(1, 8'h55, 8'h55, 0, 1);
        cycle(1, 8'h55, 8'h55, 0, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h3C, 8'h3C, 0, 1);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL p5_early_valid beat=%0d got=1 exp=0", i);
            end
        end
        cycle(1, 8'h3C, 8'h3C, 0, 1);
        checks += 3;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL p5_valid got=%0b exp=1", out_valid);
        end
        if (out_count !== 6'd32) begin
            failures++; $display("FAIL p5_count got=%0d exp=32", out_count);
        end
        if (out_beats !== 3'd4) begin
            failures++; $display("FAIL p5_beats got=%0d exp=4", out_beats);
        end
        // Reset while a result is pending drops out_valid at once.
        do_reset();
    endtask

    task automatic test_gapped();
        cycle(1, 8'hC3, 8'hC3, 0, 1);
        cycle(0, 8'h00, 8'hFF, 0, 1);
        cycle(1, 8'hC3, 8'hC3, 0, 1);
        cycle(0, 8'h00, 8'hFF, 1, 1);
        cycle(1, 8'hC3, 8'hC3, 0, 1);
        cycle(0, 8'h00, 8'hFF, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL p6_early_valid got=%0b exp=0", out_valid);
        end
        cycle(1, 8'hC3, 8'hC3, 0, 1);
        checks += 3;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL p6_valid got=%0b exp=1", out_valid);
        end
        if (out_beats !== 3'd4) begin
            failures++; $display("FAIL p6_beats got=%0d exp=4", out_beats);
        end
        if (out_count !== 6'd32) begin
            failures++; $display("FAIL p6_count got=%0d exp=32", out_count);
        end
        cycle(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [7:0] y;
        for (int n = 0; n < 400; n++) begin
            x = 8'($urandom);
            y = ($urandom_range(0, 2) == 0) ? x : 8'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), x, y,
                  1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 2) != 0));
            checks += 2;
            if (out_valid !== m_done) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, out_valid, m_done);
            end
            if (in_ready !== !m_done) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", n, in_ready, !m_done);
            end
            if (m_done) begin
                checks += 3;
                if (out_count !== 6'(m_cnt)) begin
                    failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, out_count, m_cnt);
                end
                if (out_beats !== 3'(m_beats)) begin
                    failures++; $display("FAIL rnd_beats cyc=%0d got=%0d exp=%0d", n, out_beats, m_beats);
                end
                if (out_match_all !== m_all) begin
                    failures++; $display("FAIL rnd_all cyc=%0d got=%0b exp=%0b", n, out_match_all, m_all);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_match();
        test_no_match();
        test_early_last();
        test_backpressure();
        test_reset_mid_frame();
        test_gapped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
